// File: rtl/ram8.sv
// Eight-word register memory: a 1-to-8 demux steers the write strobe to one word
// register, and an 8-way mux returns the addressed word combinationally.

module Ram8Bit (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    input  logic i_load,
    output logic o_q
);
    logic r_q;

    // Holding on !i_load keeps an unknown i_d from ever reaching the stored bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

module Ram8Word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_q
);
    genvar b;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_bit
            Ram8Bit u_bit (
                .clk    (clk),
                .reset  (reset),
                .i_d    (i_d[b]),
                .i_load (i_load),
                .o_q    (o_q[b])
            );
        end
    endgenerate
endmodule

module Ram8DMux8Way (
    input  logic       i_in,
    input  logic [2:0] i_sel,
    output logic [7:0] o_out
);
    always_comb begin
        o_out        = 8'b0;
        o_out[i_sel] = i_in;
    end
endmodule

module Ram8Mux8Way #(
    parameter int WIDTH = 16
) (
    input  logic [7:0][WIDTH-1:0] i_words,
    input  logic [2:0]            i_sel,
    output logic [WIDTH-1:0]      o_out
);
    always_comb begin
        o_out = i_words[i_sel];
    end
endmodule

module ram8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [0:2]       address,
    output logic [WIDTH-1:0] out
);
    logic [2:0]            w_index;
    logic [7:0]            w_enable;
    logic [7:0][WIDTH-1:0] w_words;

    // address[0] is the least significant bit of the word index.
    assign w_index = {address[2], address[1], address[0]};

    Ram8DMux8Way u_dmux (
        .i_in  (load),
        .i_sel (w_index),
        .o_out (w_enable)
    );

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_word
            Ram8Word #(.WIDTH(WIDTH)) u_word (
                .clk    (clk),
                .reset  (reset),
                .i_d    (in),
                .i_load (w_enable[k]),
                .o_q    (w_words[k])
            );
        end
    endgenerate

    Ram8Mux8Way #(.WIDTH(WIDTH)) u_mux (
        .i_words (w_words),
        .i_sel   (w_index),
        .o_out   (out)
    );
endmodule

// File: doc/ram8.md
Name: ram8

Overview:
Eight-word register memory, the direct consumer of the 1-to-8 demultiplexer's outputs. The demux steers the `load` strobe to exactly one of eight word registers, and an 8-way multiplexer returns the addressed word on `out`. It is the base storage stage of the memory hierarchy; RAM64 and larger blocks are built from it.

Parameters:
WIDTH, 16, bits per stored word and width of `in`/`out`.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high; clears all eight words on the next rising edge.
in  input  WIDTH  write data.
load  input  1  write enable; when high, the addressed word captures `in` at the rising edge.
address  input  [0:2] (3)  word select. `address[0]` is the LSB. The word index is k = address[0] + 2*address[1] + 4*address[2].
out  output  WIDTH  contents of word k; combinational read.

Behaviour:
- Storage: eight WIDTH-bit registers, word0..word7.
- Reset, synchronous:
  - At a rising edge with `reset`=1, all words become 0, regardless of `load`, `address` or `in`. Reset has priority over write.
  - `out` therefore reads 0 from the cycle after reset, for every address.
  - Before the first reset edge, word contents are undefined; the bench must not check them.
- Write decode:
  - `load` is routed through the 1-to-8 demux using `address`, giving per-word enables en0..en7.
  - Exactly one enable equals `load`; the other seven are 0.
- Write timing:
  - At a rising edge with `reset`=0 and `load`=1, word k <= `in`. All other words hold.
  - With `load`=0, all words hold.
- Read:
  - `out` = word k, purely combinational from `address` and the stored words. There is no read latency.
  - A write becomes visible on `out` only after the clock edge. In the same cycle as a write to k, `out` still shows the old word k (read-before-write).
- Read and write share `address`: one port, so read and write always target the same word.
- Address changes mid-cycle:
  - `out` follows the new address combinationally.
  - The write target is whatever `address` holds at the rising edge.
- Back-to-back writes:
  - Consecutive cycles with `load`=1 to the same k: the last value wins, one update per edge.
  - Writes to different k in consecutive cycles are independent.
- X-handling: with `load`=0, an unknown `in` must not corrupt any word.
- Structure: the per-word register is a WIDTH-bit bank of load-enabled bit registers. Data flow is `in` -> word registers -> 8-way mux -> `out`; there are no other paths.

Test Plan:
- Reset clears all words: write 16'hFFFF to all 8 addresses, then assert `reset` for 1 cycle with `load`=1, `in`=16'h1234, address=5 -> at every address 0..7, `out`=16'h0000 (reset beats write).
- Write/read each word: after reset, write in=16'h1000+k at address k for k=0..7, one per cycle. Then sweep addresses with `load`=0 -> `out`=16'h1000+k at each k. This checks the address bit order: address[0]=1 alone selects word 1, address[2]=1 alone selects word 4.
- Read-before-write: word 3 holds 16'hAAAA; drive address=3, in=16'h5555, load=1 -> `out`=16'hAAAA during that cycle, 16'h5555 the cycle after.
- Isolation: word 6 holds 16'h0F0F; write 16'hFFFF to address 7 for 4 cycles -> word 6 still reads 16'h0F0F, and words 0..5 are unchanged.
- Load low holds: drive address=2 with load=0 and `in` toggling (16'h0001, 16'h8000, 16'hXXXX) for 5 cycles -> word 2 keeps its prior value 16'h1002.
- Reset mid-sequence: during back-to-back writes, pulse `reset` for one cycle -> all words read 0. Writes resume normally on the next cycle: address=1, in=16'h00C3 -> `out`=16'h00C3.
